// File: rtl/boot_pkg.sv
// Shared definitions for the serial boot loader.
//   boot_state_t   : loader FSM state encoding
//   MAGIC_DEFAULT  : default frame start byte
//   BYTES_PER_WORD : bytes packed into each RAM word
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } boot_state_t;

    localparam logic [7:0] MAGIC_DEFAULT  = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_loader.sv
// Serial boot loader. Pulls a framed image out of the UART RX FIFO,
// packs it little-endian into 32-bit words written from RAM word 0,
// verifies an 8-bit additive checksum and then releases the CPU.
//
// Frame: MAGIC, LEN_LO, LEN_HI, 4*N data bytes, checksum byte.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | hunting for MAGIC, other bytes discarded
// LEN_LO   | capture low byte of word count N
// LEN_HI   | capture high byte of N, range-check it
// DATA     | shift data bytes into the word register, sum them
// WRITE    | one-cycle RAM write of the assembled word
// CSUM     | compare received checksum with running sum
// DONE     | image verified, CPU released (terminal until reset)
// ERR      | frame rejected, waiting for the next MAGIC
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous active-low reset
//   i_rx_empty   RX FIFO empty
//   i_rx_data    RX FIFO head byte
//   o_rd_uart    RX FIFO pop strobe
//   o_ram_addr   RAM word address
//   o_ram_wdata  RAM write data
//   o_ram_we     RAM byte enables (all or none)
//   o_busy       loader owns RAM / UART read path
//   o_cpu_hold   CPU reset request
//   o_done       image loaded and verified (sticky)
//   o_err        last frame failed
module boot_loader
    import boot_pkg::*;
#(
    parameter int         ADDR_W = 11,
    parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_empty,
    input  logic [7:0]        i_rx_data,
    output logic              o_rd_uart,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    output logic [3:0]        o_ram_we,
    output logic              o_busy,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_err
);

    // Largest legal image: 2**ADDR_W words.
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

    boot_state_t       r_state;
    boot_state_t       w_next;

    logic [15:0]       r_len;
    logic [ADDR_W:0]   r_word_cnt;
    logic [1:0]        r_byte_cnt;
    logic [31:0]       r_word;
    logic [7:0]        r_sum;

    logic              w_accept;
    logic              w_pop;
    logic              w_magic;
    logic [15:0]       w_len_n;
    logic [ADDR_W:0]   w_cnt_inc;
    logic              w_last_word;
    logic              w_last_byte;

    assign w_accept = (r_state == ST_IDLE)   || (r_state == ST_LEN_LO) ||
                      (r_state == ST_LEN_HI) || (r_state == ST_DATA)   ||
                      (r_state == ST_CSUM)   || (r_state == ST_ERR);
    assign w_pop       = w_accept && !i_rx_empty;
    assign w_magic     = (i_rx_data == MAGIC);
    assign w_len_n     = {i_rx_data, r_len[7:0]};
    assign w_cnt_inc   = r_word_cnt + {{ADDR_W{1'b0}}, 1'b1};
    assign w_last_word = (16'(w_cnt_inc) == r_len);
    assign w_last_byte = (r_byte_cnt == 2'(BYTES_PER_WORD - 1));

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (w_pop && w_magic) w_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (w_pop) w_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (w_pop) begin
                    if (w_len_n == 16'd0)             w_next = ST_DONE;
                    else if ({1'b0, w_len_n} > MAX_LEN) w_next = ST_ERR;
                    else                              w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_pop && w_last_byte) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_next = w_last_word ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
                if (w_pop) w_next = (i_rx_data == r_sum) ? ST_DONE : ST_ERR;
            end
            ST_DONE: begin
                w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath: length capture, byte packer, sum and word counter
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_len      <= '0;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_sum      <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ERR: begin
                    if (w_pop && w_magic) begin
                        r_word_cnt <= '0;
                        r_byte_cnt <= '0;
                        r_sum      <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (w_pop) r_len[7:0] <= i_rx_data;
                end
                ST_LEN_HI: begin
                    if (w_pop) r_len[15:8] <= i_rx_data;
                end
                ST_DATA: begin
                    if (w_pop) begin
                        // Shift right so the first byte lands in [7:0] after four pops.
                        r_word     <= {i_rx_data, r_word[31:8]};
                        r_sum      <= r_sum + i_rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                ST_WRITE: begin
                    r_word_cnt <= w_cnt_inc;
                    r_byte_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        o_rd_uart   = w_pop;
        o_ram_addr  = r_word_cnt[ADDR_W-1:0];
        o_ram_wdata = r_word;
        o_ram_we    = 4'b0000;
        o_busy      = 1'b1;
        o_cpu_hold  = 1'b1;
        o_done      = 1'b0;
        o_err       = 1'b0;
        case (r_state)
            ST_WRITE: o_ram_we = 4'b1111;
            ST_DONE: begin
                o_busy     = 1'b0;
                o_cpu_hold = 1'b0;
                o_done     = 1'b1;
            end
            ST_ERR:   o_err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;
    import boot_pkg::*;

    localparam int ADDR_W = 11;

    logic              clk;
    logic              rst_n;
    logic              rx_empty;
    logic [7:0]        rx_data;
    logic              rd_uart;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_we;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [31:0]        mem [0:15];
    int                 we_count = 0;
    bit                 prev_we  = 0;
    bit                 mon_en   = 0;

    boot_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_rx_empty  (rx_empty),
        .i_rx_data   (rx_data),
        .o_rd_uart   (rd_uart),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .o_ram_we    (ram_we),
        .o_busy      (busy),
        .o_cpu_hold  (cpu_hold),
        .o_done      (done),
        .o_err       (err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Write monitor: pops the scoreboard on every RAM write.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ram_we !== 4'b0000) begin
                logic [ADDR_W+31:0] e;
                n_tests++;
                we_count++;
                if (ram_we !== 4'b1111) begin
                    n_fail++;
                    $display("FAIL ram_we_encoding: got %b expected 1111", ram_we);
                end else if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data %h with no write expected", ram_addr, ram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({ram_addr, ram_wdata} !== e) begin
                        n_fail++;
                        $display("FAIL write_content: got addr %0d data %h expected addr %0d data %h",
                                 ram_addr, ram_wdata, e[ADDR_W+31:32], e[31:0]);
                    end
                    if (ram_addr < 16) mem[ram_addr[3:0]] = ram_wdata;
                end
                if (prev_we) begin
                    n_fail++;
                    $display("FAIL we_pulse_width: ram_we high on consecutive cycles, expected 1-cycle pulse");
                end
            end
            prev_we = (ram_we !== 4'b0000);
        end
    end

    // Presents one byte after 'gap' empty cycles; returns on the negedge after it is popped.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        rx_empty = 1;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_empty = 0;
        #1;
        while (!rd_uart && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!rd_uart) begin
            n_tests++;
            n_fail++;
            $display("FAIL pop_timeout: byte %h not popped, rd_uart=%b expected 1", b, rd_uart);
            rx_empty = 1;
        end else begin
            @(negedge clk);
            rx_empty = 1;
        end
    endtask

    function automatic logic [7:0] csum_of(input logic [7:0] d[$]);
        logic [7:0] s = 8'h00;
        foreach (d[i]) s = s + d[i];
        return s;
    endfunction

    // Sends MAGIC, length and data bytes; the checksum is left to the caller.
    task automatic load_frame(input logic [7:0] d[$], input int gap);
        int n;
        logic [15:0] len;
        n   = d.size() / 4;
        len = 16'(n);
        send_byte(8'hA5, gap);
        send_byte(len[7:0], gap);
        send_byte(len[15:8], gap);
        for (int i = 0; i < d.size(); i++) begin
            if (i % 4 == 3)
                exp_q.push_back({11'(i / 4), d[i], d[i-1], d[i-2], d[i-3]});
            send_byte(d[i], gap);
            if (i % 4 == 3) begin
                n_tests++;
                if (ram_we !== 4'b1111) begin
                    n_fail++;
                    $display("FAIL write_latency: ram_we=%b after 4th byte of word %0d, expected 1111", ram_we, i / 4);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 0;
        rx_empty = 1;
        @(negedge clk);
        rst_n = 1;
        exp_q.delete();
        prev_we = 0;
    endtask

    task automatic check_done(input string tag);
        n_tests++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: done=%b cpu_hold=%b busy=%b err=%b expected 1 0 0 0", tag, done, cpu_hold, busy, err);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_writes_missing: %0d expected writes outstanding, expected 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n    = 0;
        rx_empty = 1;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1;
        n_tests++;
        if (busy !== 1 || cpu_hold !== 1 || done !== 0 || err !== 0 || ram_we !== 4'b0000 || rd_uart !== 0) begin
            n_fail++;
            $display("FAIL reset_values: busy=%b hold=%b done=%b err=%b we=%b rd=%b expected 1 1 0 0 0000 0",
                     busy, cpu_hold, done, err, ram_we, rd_uart);
        end
        mon_en = 1;
    endtask

    task automatic test_basic();
        logic [7:0] d[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_reset();
        load_frame(d, 0);
        n_tests++;
        if (done !== 0 || cpu_hold !== 1) begin
            n_fail++;
            $display("FAIL basic_early_done: done=%b cpu_hold=%b before checksum, expected 0 1", done, cpu_hold);
        end
        send_byte(8'h64, 0);
        check_done("basic");
        n_tests++;
        if (mem[0] !== 32'h44332211 || mem[1] !== 32'h88776655) begin
            n_fail++;
            $display("FAIL basic_ram: RAM0=%h RAM1=%h expected 44332211 88776655", mem[0], mem[1]);
        end
        // After DONE the FIFO belongs to the CPU.
        rx_data  = 8'hA5;
        rx_empty = 0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (rd_uart !== 0 || done !== 1) begin
            n_fail++;
            $display("FAIL done_no_pop: rd_uart=%b done=%b with data waiting, expected 0 1", rd_uart, done);
        end
        rx_empty = 1;
    endtask

    task automatic test_bad_csum();
        logic [7:0] d[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_reset();
        load_frame(d, 0);
        send_byte(8'h65, 0);
        n_tests++;
        if (err !== 1 || cpu_hold !== 1 || done !== 0 || busy !== 1) begin
            n_fail++;
            $display("FAIL bad_csum_err: err=%b hold=%b done=%b busy=%b expected 1 1 0 1", err, cpu_hold, done, busy);
        end
        load_frame(d, 0);
        n_tests++;
        if (err !== 0) begin
            n_fail++;
            $display("FAIL err_clear: err=%b after resend from error, expected 0", err);
        end
        send_byte(8'h64, 0);
        check_done("resend");
    endtask

    task automatic test_junk();
        logic [7:0] d[$] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_reset();
        mem[0] = 32'h0;
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        load_frame(d, 0);
        send_byte(csum_of(d), 0);
        check_done("junk");
        n_tests++;
        if (mem[0] !== 32'hEFBEADDE) begin
            n_fail++;
            $display("FAIL junk_ram: RAM0=%h expected efbeadde", mem[0]);
        end
    endtask

    task automatic test_length_bounds();
        int wc0;
        do_reset();
        wc0 = we_count;
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h08, 0);
        n_tests++;
        if (err !== 1 || done !== 0) begin
            n_fail++;
            $display("FAIL len_too_big: err=%b done=%b for N=2049, expected 1 0", err, done);
        end
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_done("empty_image");
        n_tests++;
        if (we_count != wc0) begin
            n_fail++;
            $display("FAIL len_bounds_writes: %0d writes seen, expected 0", we_count - wc0);
        end
    endtask

    task automatic test_gappy();
        logic [7:0] d[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        int wc0;
        do_reset();
        mem[0] = 32'h0;
        mem[1] = 32'h0;
        wc0 = we_count;
        load_frame(d, 3);
        send_byte(csum_of(d), 3);
        check_done("gappy");
        n_tests++;
        if (mem[0] !== 32'h44332211 || mem[1] !== 32'h88776655 || we_count - wc0 != 2) begin
            n_fail++;
            $display("FAIL gappy_ram: RAM0=%h RAM1=%h writes=%0d expected 44332211 88776655 2",
                     mem[0], mem[1], we_count - wc0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d[$] = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
        int wc0;
        do_reset();
        wc0 = we_count;
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        n_tests++;
        if (busy !== 1 || cpu_hold !== 1 || ram_we !== 4'b0000 || err !== 0 || done !== 0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b hold=%b we=%b err=%b done=%b expected 1 1 0000 0 0",
                     busy, cpu_hold, ram_we, err, done);
        end
        mem[0] = 32'h0;
        load_frame(d, 0);
        send_byte(csum_of(d), 0);
        check_done("after_reset");
        n_tests++;
        if (mem[0] !== 32'hBEBAFECA || we_count - wc0 != 1) begin
            n_fail++;
            $display("FAIL reset_mid_ram: RAM0=%h writes=%0d expected bebafeca 1", mem[0], we_count - wc0);
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 32'h0;
        test_reset();
        test_basic();
        test_bad_csum();
        test_junk();
        test_length_bounds();
        test_gappy();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
